// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS-subset instruction-decode stage with IF/ID and ID/EX registers
//
// Purpose:
//   Latches fetched instructions into IF/ID, addresses the register file,
//   applies same-cycle write-back bypass, decodes control signals, detects
//   load-use hazards, resolves beq and registers the result into ID/EX.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc      fetch handshake (accepted when id_ready)
//   id_ready                     ID can take the presented instruction
//   flush                        kill IF/ID and ID/EX contents
//   reg_raddr1/2, reg_data1/2    asynchronous register-file read port
//   wb_reg_write/waddr/wdata     write-back port, used for bypass
//   ex_mem_read, ex_rd           load currently in EX (hazard detection)
//   br_taken, br_target          combinational beq resolution
//   idex_*                       ID/EX pipeline register outputs
module id_stage #(
    parameter int WORD_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    input  logic [WORD_WIDTH-1:0]    if_instr,
    input  logic [WORD_WIDTH-1:0]    if_pc,
    output logic                     id_ready,
    input  logic                     flush,
    output logic [REGADDR_WIDTH-1:0] reg_raddr1,
    output logic [REGADDR_WIDTH-1:0] reg_raddr2,
    input  logic [WORD_WIDTH-1:0]    reg_data1,
    input  logic [WORD_WIDTH-1:0]    reg_data2,
    input  logic                     wb_reg_write,
    input  logic [REGADDR_WIDTH-1:0] wb_waddr,
    input  logic [WORD_WIDTH-1:0]    wb_wdata,
    input  logic                     ex_mem_read,
    input  logic [REGADDR_WIDTH-1:0] ex_rd,
    output logic                     br_taken,
    output logic [WORD_WIDTH-1:0]    br_target,
    output logic                     idex_valid,
    output logic [WORD_WIDTH-1:0]    idex_pc,
    output logic [WORD_WIDTH-1:0]    idex_rs_data,
    output logic [WORD_WIDTH-1:0]    idex_rt_data,
    output logic [WORD_WIDTH-1:0]    idex_imm,
    output logic [REGADDR_WIDTH-1:0] idex_rs,
    output logic [REGADDR_WIDTH-1:0] idex_rt,
    output logic [REGADDR_WIDTH-1:0] idex_rd,
    output logic [2:0]               idex_alu_op,
    output logic                     idex_alu_src,
    output logic                     idex_mem_read,
    output logic                     idex_mem_write,
    output logic                     idex_reg_write,
    output logic                     idex_mem_to_reg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    logic                  ifid_valid_q, ifid_valid_d;
    logic [WORD_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [WORD_WIDTH-1:0] ifid_pc_q,    ifid_pc_d;

    // Decoded instruction fields
    logic [5:0]               op;
    logic [5:0]               funct;
    logic [REGADDR_WIDTH-1:0] rs;
    logic [REGADDR_WIDTH-1:0] rt;
    logic [REGADDR_WIDTH-1:0] rd;
    logic [WORD_WIDTH-1:0]    imm;

    assign op    = ifid_instr_q[31:26];
    assign rs    = ifid_instr_q[25:21];
    assign rt    = ifid_instr_q[20:16];
    assign rd    = ifid_instr_q[15:11];
    assign funct = ifid_instr_q[5:0];
    assign imm   = {{(WORD_WIDTH-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    assign reg_raddr1 = rs;
    assign reg_raddr2 = rt;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [2:0]               dec_alu_op;
    logic                     dec_alu_src;
    logic                     dec_mem_read;
    logic                     dec_mem_write;
    logic                     dec_reg_write;
    logic                     dec_mem_to_reg;
    logic [REGADDR_WIDTH-1:0] dec_dest;
    logic                     dec_rt_src;   // rt is read as an operand

    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_dest       = '0;
        dec_rt_src     = 1'b0;
        case (op)
            OP_RTYPE: begin
                // rt is a source for any R-type, even an unrecognised funct,
                // so hazard detection stays conservative.
                dec_rt_src = 1'b1;
                case (funct)
                    FN_ADD: begin dec_alu_op = ALU_ADD; dec_reg_write = 1'b1; dec_dest = rd; end
                    FN_SUB: begin dec_alu_op = ALU_SUB; dec_reg_write = 1'b1; dec_dest = rd; end
                    FN_AND: begin dec_alu_op = ALU_AND; dec_reg_write = 1'b1; dec_dest = rd; end
                    FN_OR:  begin dec_alu_op = ALU_OR;  dec_reg_write = 1'b1; dec_dest = rd; end
                    FN_SLT: begin dec_alu_op = ALU_SLT; dec_reg_write = 1'b1; dec_dest = rd; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_dest      = rt;
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_dest       = rt;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_rt_src    = 1'b1;
            end
            OP_BEQ: begin
                dec_rt_src = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand fetch with write-back bypass; r0 always reads as zero
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] operand1;
    logic [WORD_WIDTH-1:0] operand2;

    always_comb begin
        if (rs == '0) begin
            operand1 = '0;
        end else if (wb_reg_write && (wb_waddr == rs)) begin
            operand1 = wb_wdata;
        end else begin
            operand1 = reg_data1;
        end

        if (rt == '0) begin
            operand2 = '0;
        end else if (wb_reg_write && (wb_waddr == rt)) begin
            operand2 = wb_wdata;
        end else begin
            operand2 = reg_data2;
        end
    end

    // ------------------------------------------------------------------
    // Hazard, handshake and branch resolution
    // ------------------------------------------------------------------
    logic hazard;
    logic accept;
    logic issue;

    assign hazard = ifid_valid_q && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == rs) || ((ex_rd == rt) && dec_rt_src));

    // A flush empties the stage, so it may always take a new beat (which the
    // flush then discards).
    assign id_ready = flush || !hazard;
    assign accept   = if_valid && id_ready && !flush;
    assign issue    = ifid_valid_q && !hazard && !flush;

    assign br_taken  = ifid_valid_q && (op == OP_BEQ) && !hazard && (operand1 == operand2);
    assign br_target = ifid_pc_q + WORD_WIDTH'(4) + (imm << 2);

    // IF/ID next state. With no new beat the current instruction has moved
    // on (or been killed by a taken branch), so the register empties; only a
    // hazard holds it.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
        end else if (accept) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = if_instr;
            ifid_pc_d    = if_pc;
        end else if (!hazard) begin
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register. Bubbles clear valid and every control bit; the data
    // fields are don't-care in a bubble and simply hold.
    // ------------------------------------------------------------------
    logic                     idex_valid_q;
    logic [WORD_WIDTH-1:0]    idex_pc_q;
    logic [WORD_WIDTH-1:0]    idex_rs_data_q;
    logic [WORD_WIDTH-1:0]    idex_rt_data_q;
    logic [WORD_WIDTH-1:0]    idex_imm_q;
    logic [REGADDR_WIDTH-1:0] idex_rs_q;
    logic [REGADDR_WIDTH-1:0] idex_rt_q;
    logic [REGADDR_WIDTH-1:0] idex_rd_q;
    logic [2:0]               idex_alu_op_q;
    logic                     idex_alu_src_q;
    logic                     idex_mem_read_q;
    logic                     idex_mem_write_q;
    logic                     idex_reg_write_q;
    logic                     idex_mem_to_reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_q      <= 1'b0;
            idex_pc_q         <= '0;
            idex_rs_data_q    <= '0;
            idex_rt_data_q    <= '0;
            idex_imm_q        <= '0;
            idex_rs_q         <= '0;
            idex_rt_q         <= '0;
            idex_rd_q         <= '0;
            idex_alu_op_q     <= '0;
            idex_alu_src_q    <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            idex_mem_write_q  <= 1'b0;
            idex_reg_write_q  <= 1'b0;
            idex_mem_to_reg_q <= 1'b0;
        end else if (issue) begin
            idex_valid_q      <= 1'b1;
            idex_pc_q         <= ifid_pc_q;
            idex_rs_data_q    <= operand1;
            idex_rt_data_q    <= operand2;
            idex_imm_q        <= imm;
            idex_rs_q         <= rs;
            idex_rt_q         <= rt;
            idex_rd_q         <= dec_dest;
            idex_alu_op_q     <= dec_alu_op;
            idex_alu_src_q    <= dec_alu_src;
            idex_mem_read_q   <= dec_mem_read;
            idex_mem_write_q  <= dec_mem_write;
            idex_reg_write_q  <= dec_reg_write;
            idex_mem_to_reg_q <= dec_mem_to_reg;
        end else begin
            idex_valid_q      <= 1'b0;
            idex_alu_op_q     <= '0;
            idex_alu_src_q    <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            idex_mem_write_q  <= 1'b0;
            idex_reg_write_q  <= 1'b0;
            idex_mem_to_reg_q <= 1'b0;
        end
    end

    assign idex_valid      = idex_valid_q;
    assign idex_pc         = idex_pc_q;
    assign idex_rs_data    = idex_rs_data_q;
    assign idex_rt_data    = idex_rt_data_q;
    assign idex_imm        = idex_imm_q;
    assign idex_rs         = idex_rs_q;
    assign idex_rt         = idex_rt_q;
    assign idex_rd         = idex_rd_q;
    assign idex_alu_op     = idex_alu_op_q;
    assign idex_alu_src    = idex_alu_src_q;
    assign idex_mem_read   = idex_mem_read_q;
    assign idex_mem_write  = idex_mem_write_q;
    assign idex_reg_write  = idex_reg_write_q;
    assign idex_mem_to_reg = idex_mem_to_reg_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed table-driven testbench for id_stage
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic [4:0]  reg_raddr1, reg_raddr2;
    logic [31:0] reg_data1, reg_data2;
    logic        wb_reg_write;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        br_taken;
    logic [31:0] br_target;
    logic        idex_valid;
    logic [31:0] idex_pc, idex_rs_data, idex_rt_data, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic [2:0]  idex_alu_op;
    logic        idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write, idex_mem_to_reg;

    id_stage #(.WORD_WIDTH(32), .REGADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush),
        .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
        .reg_data1(reg_data1), .reg_data2(reg_data2),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .br_taken(br_taken), .br_target(br_target),
        .idex_valid(idex_valid), .idex_pc(idex_pc),
        .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_alu_op(idex_alu_op), .idex_alu_src(idex_alu_src),
        .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
        .idex_reg_write(idex_reg_write), .idex_mem_to_reg(idex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // ctl = {alu_src, mem_read, mem_write, reg_write, mem_to_reg}
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exp_br;
        logic [31:0] exp_tgt;
        logic [31:0] exp_rs_data;
        logic [31:0] exp_rt_data;
        logic [4:0]  exp_rd;
        logic [2:0]  exp_alu;
        logic [4:0]  exp_ctl;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic wb_we, input logic [4:0] wb_addr,
                                input logic [31:0] wb_data, input logic exp_br,
                                input logic [31:0] exp_tgt, input logic [31:0] exp_rs_data,
                                input logic [31:0] exp_rt_data, input logic [4:0] exp_rd,
                                input logic [2:0] exp_alu, input logic [4:0] exp_ctl);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2;
        v.wb_we = wb_we; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.exp_br = exp_br; v.exp_tgt = exp_tgt;
        v.exp_rs_data = exp_rs_data; v.exp_rt_data = exp_rt_data;
        v.exp_rd = exp_rd; v.exp_alu = exp_alu; v.exp_ctl = exp_ctl;
        return v;
    endfunction

    vec_t vecs[16];

    function automatic logic [4:0] ctl_now();
        return {idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write, idex_mem_to_reg};
    endfunction

    task automatic idle_inputs();
        if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
        reg_data1 = 0; reg_data2 = 0;
        wb_reg_write = 0; wb_waddr = 0; wb_wdata = 0;
        ex_mem_read = 0; ex_rd = 0;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] ins;
        logic [31:0] exp_imm;

        vecs[0]  = mk(r_ins(1, 2, 3, 6'h20), 32'h40, 5, 7, 0, 0, 0, 0, 0, 5, 7, 3, 0, 5'b00010);
        vecs[1]  = mk(r_ins(4, 2, 5, 6'h22), 32'h44, 10, 3, 0, 0, 0, 0, 0, 10, 3, 5, 1, 5'b00010);
        vecs[2]  = mk(r_ins(1, 2, 6, 6'h24), 32'h48, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0,
                      32'hF0F0, 32'hFF00, 6, 2, 5'b00010);
        vecs[3]  = mk(r_ins(1, 2, 7, 6'h25), 32'h4C, 1, 2, 0, 0, 0, 0, 0, 1, 2, 7, 3, 5'b00010);
        vecs[4]  = mk(r_ins(1, 2, 8, 6'h2A), 32'h50, 3, 4, 0, 0, 0, 0, 0, 3, 4, 8, 4, 5'b00010);
        vecs[5]  = mk(i_ins(6'h08, 1, 9, 16'hFFFD), 32'h54, 32'h20, 32'h77, 0, 0, 0, 0, 0,
                      32'h20, 32'h77, 9, 0, 5'b10010);
        vecs[6]  = mk(i_ins(6'h23, 1, 4, 16'h0008), 32'h58, 32'h100, 0, 0, 0, 0, 0, 0,
                      32'h100, 0, 4, 0, 5'b11011);
        vecs[7]  = mk(i_ins(6'h2B, 1, 2, 16'h0010), 32'h5C, 32'h100, 32'hABCD, 0, 0, 0, 0, 0,
                      32'h100, 32'hABCD, 0, 0, 5'b10100);
        vecs[8]  = mk(r_ins(1, 2, 10, 6'h20), 32'h60, 32'h11, 32'hDEAD, 1, 2, 32'h1234, 0, 0,
                      32'h11, 32'h1234, 10, 0, 5'b00010);
        vecs[9]  = mk(r_ins(0, 2, 12, 6'h20), 32'h64, 32'h99, 8, 1, 0, 32'h55, 0, 0,
                      0, 8, 12, 0, 5'b00010);
        vecs[10] = mk(i_ins(6'h3F, 1, 2, 16'h1234), 32'h68, 3, 4, 0, 0, 0, 0, 0, 3, 4, 0, 0, 5'b00000);
        vecs[11] = mk(i_ins(6'h04, 1, 1, 16'hFFFF), 32'h100, 5, 5, 0, 0, 0, 1, 32'h100,
                      5, 5, 0, 0, 5'b00000);
        vecs[12] = mk(i_ins(6'h04, 1, 2, 16'hFFFF), 32'h200, 5, 6, 0, 0, 0, 0, 0, 5, 6, 0, 0, 5'b00000);
        vecs[13] = mk(i_ins(6'h04, 1, 2, 16'h0002), 32'h300, 9, 4, 1, 2, 9, 1, 32'h30C,
                      9, 9, 0, 0, 5'b00000);
        vecs[14] = mk(r_ins(1, 2, 13, 6'h00), 32'h304, 1, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 5'b00000);
        vecs[15] = mk(r_ins(7, 7, 14, 6'h20), 32'h308, 1, 1, 1, 7, 32'hCAFE, 0, 0,
                      32'hCAFE, 32'hCAFE, 14, 0, 5'b00010);

        // ---------------- reset ----------------
        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("rst_id_ready", {31'd0, id_ready}, 1);
        chk("rst_br_taken", {31'd0, br_taken}, 0);
        chk("rst_raddr1", {27'd0, reg_raddr1}, 0);
        chk("rst_raddr2", {27'd0, reg_raddr2}, 0);
        chk("rst_idex_valid", {31'd0, idex_valid}, 0);
        chk("rst_idex_pc", idex_pc, 0);
        chk("rst_idex_ctl", {27'd0, ctl_now()}, 0);
        tick();
        tick();
        rst_n = 1;
        tick();

        // ---------------- table ----------------
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            ins = v.instr;
            exp_imm = {{16{ins[15]}}, ins[15:0]};
            idle_inputs();
            if_valid = 1; if_instr = v.instr; if_pc = v.pc;
            tick();
            idle_inputs();
            reg_data1 = v.rd1; reg_data2 = v.rd2;
            wb_reg_write = v.wb_we; wb_waddr = v.wb_addr; wb_wdata = v.wb_data;
            #1;
            chk($sformatf("v%0d_raddr1", i), {27'd0, reg_raddr1}, {27'd0, ins[25:21]});
            chk($sformatf("v%0d_raddr2", i), {27'd0, reg_raddr2}, {27'd0, ins[20:16]});
            chk($sformatf("v%0d_br_taken", i), {31'd0, br_taken}, {31'd0, v.exp_br});
            if (v.exp_br) chk($sformatf("v%0d_br_target", i), br_target, v.exp_tgt);
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, idex_valid}, 1);
            chk($sformatf("v%0d_pc", i), idex_pc, v.pc);
            chk($sformatf("v%0d_rs_data", i), idex_rs_data, v.exp_rs_data);
            chk($sformatf("v%0d_rt_data", i), idex_rt_data, v.exp_rt_data);
            chk($sformatf("v%0d_imm", i), idex_imm, exp_imm);
            chk($sformatf("v%0d_rs", i), {27'd0, idex_rs}, {27'd0, ins[25:21]});
            chk($sformatf("v%0d_rt", i), {27'd0, idex_rt}, {27'd0, ins[20:16]});
            chk($sformatf("v%0d_rd", i), {27'd0, idex_rd}, {27'd0, v.exp_rd});
            chk($sformatf("v%0d_alu_op", i), {29'd0, idex_alu_op}, {29'd0, v.exp_alu});
            chk($sformatf("v%0d_ctl", i), {27'd0, ctl_now()}, {27'd0, v.exp_ctl});
        end
        idle_inputs();
        tick();

        // ---------------- load-use stall on rs ----------------
        if_valid = 1; if_instr = r_ins(4, 2, 5, 6'h22); if_pc = 32'h500;
        tick();
        if_instr = r_ins(1, 2, 3, 6'h20); if_pc = 32'h504;
        ex_mem_read = 1; ex_rd = 4;
        reg_data1 = 32'h40; reg_data2 = 3;
        #1;
        chk("lu_id_ready_stall", {31'd0, id_ready}, 0);
        tick();
        chk("lu_bubble_valid", {31'd0, idex_valid}, 0);
        chk("lu_bubble_ctl", {27'd0, ctl_now()}, 0);
        ex_mem_read = 0; ex_rd = 0;
        #1;
        chk("lu_id_ready_after", {31'd0, id_ready}, 1);
        chk("lu_held_raddr1", {27'd0, reg_raddr1}, 4);
        tick();
        chk("lu_sub_valid", {31'd0, idex_valid}, 1);
        chk("lu_sub_alu", {29'd0, idex_alu_op}, 1);
        chk("lu_sub_rd", {27'd0, idex_rd}, 5);
        chk("lu_sub_pc", idex_pc, 32'h500);
        chk("lu_next_raddr1", {27'd0, reg_raddr1}, 1);
        if_valid = 0;
        tick();
        chk("lu_add_rd", {27'd0, idex_rd}, 3);
        chk("lu_add_pc", idex_pc, 32'h504);
        idle_inputs();
        tick();

        // ---------------- rt as destination: no hazard ----------------
        if_valid = 1; if_instr = i_ins(6'h08, 1, 4, 16'h0001); if_pc = 32'h580;
        tick();
        if_valid = 0; ex_mem_read = 1; ex_rd = 4;
        #1;
        chk("addi_rt_no_hazard", {31'd0, id_ready}, 1);
        tick();
        chk("addi_issue_valid", {31'd0, idex_valid}, 1);
        idle_inputs();
        tick();

        // ---------------- rt as source (sw): hazard ----------------
        if_valid = 1; if_instr = i_ins(6'h2B, 1, 4, 16'h0000); if_pc = 32'h590;
        tick();
        if_valid = 0; ex_mem_read = 1; ex_rd = 4;
        #1;
        chk("sw_rt_hazard", {31'd0, id_ready}, 0);
        tick();
        ex_mem_read = 0; ex_rd = 0;
        chk("sw_bubble_valid", {31'd0, idex_valid}, 0);
        tick();
        chk("sw_issue_valid", {31'd0, idex_valid}, 1);
        chk("sw_issue_memw", {31'd0, idex_mem_write}, 1);
        idle_inputs();
        tick();

        // ---------------- flush during a stall ----------------
        if_valid = 1; if_instr = r_ins(4, 2, 5, 6'h22); if_pc = 32'h600;
        tick();
        if_pc = 32'h604;
        ex_mem_read = 1; ex_rd = 4; flush = 1;
        #1;
        chk("fl_id_ready", {31'd0, id_ready}, 1);
        tick();
        flush = 0; if_valid = 0;
        #1;
        chk("fl_idex_valid", {31'd0, idex_valid}, 0);
        chk("fl_ifid_empty", {31'd0, id_ready}, 1);
        chk("fl_br_taken", {31'd0, br_taken}, 0);
        tick();
        chk("fl_nothing_issued", {31'd0, idex_valid}, 0);
        idle_inputs();

        // ---------------- flush kills a would-be issue ----------------
        if_valid = 1; if_instr = r_ins(1, 2, 3, 6'h20); if_pc = 32'h620;
        tick();
        if_valid = 0; flush = 1;
        tick();
        flush = 0;
        chk("fl2_idex_valid", {31'd0, idex_valid}, 0);
        chk("fl2_idex_regw", {31'd0, idex_reg_write}, 0);
        tick();

        // ---------------- asynchronous reset mid-stream ----------------
        if_valid = 1; if_instr = r_ins(1, 2, 3, 6'h20); if_pc = 32'h680;
        tick();
        if_valid = 0; reg_data1 = 5; reg_data2 = 7;
        tick();
        chk("ar_pre_valid", {31'd0, idex_valid}, 1);
        // put a stalled sub into IF/ID behind it
        if_valid = 1; if_instr = r_ins(4, 2, 5, 6'h22); if_pc = 32'h684;
        tick();
        if_valid = 0; ex_mem_read = 1; ex_rd = 4;
        #1;
        chk("ar_stalled", {31'd0, id_ready}, 0);
        #1 rst_n = 0;
        #1;
        chk("ar_idex_valid", {31'd0, idex_valid}, 0);
        chk("ar_idex_regw", {31'd0, idex_reg_write}, 0);
        chk("ar_idex_rs_data", idex_rs_data, 0);
        chk("ar_id_ready", {31'd0, id_ready}, 1);
        tick();
        rst_n = 1;
        idle_inputs();
        if_valid = 1; if_instr = r_ins(1, 2, 3, 6'h20); if_pc = 32'h700;
        tick();
        if_valid = 0; reg_data1 = 5; reg_data2 = 7;
        #1;
        chk("ar_post_raddr1", {27'd0, reg_raddr1}, 1);
        tick();
        chk("ar_post_valid", {31'd0, idex_valid}, 1);
        chk("ar_post_pc", idex_pc, 32'h700);
        chk("ar_post_rd", {27'd0, idex_rd}, 3);
        chk("ar_post_rs_data", idex_rs_data, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
